turn_timer_scheduler: RTL and testbench
=======================================

// Module: turn_timer_scheduler
// PURPOSE
//   Round-robin turn scheduler for the multi-player game. It shares a single
//   seconds time base (a 1 s tick from the pulse prescaler) between players.
//   Each active player gets one turn of TURN_SEC seconds, or less if that
//   player signals done early. The block also gates the prescaler
//   (tick_en, clear_time) and reports the current player and remaining seconds
//   to the display logic.
// PARAMETERS
//   N_PLAYERS  4   number of player slots (2..8)
//   PW         2   width of a player index; must satisfy 2^PW >= N_PLAYERS
//   TURN_SEC   30  seconds per turn (1..2^SW-1)
//   SW         6   width of the seconds counter
// PORTS
//   clk            in   1          system clock
//   rst            in   1          synchronous reset, active-low
//   start          in   1          1-cycle pulse; begins the game from IDLE
//   abort          in   1          level; forces IDLE from any state
//   pause          in   1          level; freezes the current turn while high
//   player_active  in   N_PLAYERS  mask of players still in the game
//   player_done    in   N_PLAYERS  per-player "end my turn" pulse
//   sec_tick       in   1          1-cycle 1 s tick from the prescaler
//   tick_en        out  1          prescaler pulse gate; high only in RUN
//   clear_time     out  1          prescaler clear; high only in LOAD
//   cur_player     out  PW         index of the player who holds the turn
//   turn_grant     out  N_PLAYERS  one-hot of cur_player in LOAD/RUN/PAUSE, else 0
//   secs_left      out  SW         seconds remaining in the current turn
//   turn_change    out  1          1-cycle pulse while in LOAD
//   turn_timeout   out  1          1-cycle pulse when a turn expires
//   busy           out  1          high in any state except IDLE
// BEHAVIOUR
//   States: IDLE, LOAD, RUN, PAUSE, NEXT. All registers are updated on posedge clk.
//   Reset (rst==0), highest priority:
//     state=IDLE; cur_player=0; secs_left=0; turn_timeout=0.
//     All decoded outputs are 0.
//   abort==1 (rst high): next state is IDLE; secs_left=0; cur_player unchanged.
//   IDLE:
//     start==1 and player_active!=0 -> LOAD, with cur_player set to the
//       lowest-index active player.
//     start with an empty mask -> stay in IDLE.
//     start in any other state is ignored.
//   LOAD (exactly 1 cycle): secs_left<=TURN_SEC; clear_time=1; turn_change=1;
//     -> RUN.
//   RUN, in priority order:
//     pause -> PAUSE; sec_tick in the same cycle is dropped.
//     player_done[cur_player] -> NEXT; beats sec_tick in the same cycle.
//     sec_tick and secs_left==1 -> secs_left<=0, turn_timeout=1 next cycle, NEXT.
//     sec_tick otherwise -> secs_left<=secs_left-1.
//     done bits of non-current players are ignored in every state.
//   PAUSE: hold all counters; tick_en=0.
//     pause==0 -> RUN, resuming with the same secs_left.
//   NEXT (1 cycle): search cur+1 .. cur+N_PLAYERS modulo N_PLAYERS in the
//     current player_active mask.
//     First hit -> LOAD with cur_player set to the hit.
//     If only the current player is active, it is re-granted.
//     Empty mask -> IDLE, secs_left=0.
//   Latency:
//     done or final tick sampled at cycle t -> NEXT at t+1, LOAD at t+2
//     (turn_change, new cur_player), RUN at t+3.
//   secs_left never wraps: it never decrements below 0 and never exceeds TURN_SEC.
//   A player dropping from player_active during its own turn does not end the
//     turn; the mask is only consulted in IDLE and NEXT.
// TESTING
//   1 rst low 3 cycles, mid-RUN -> IDLE, all outputs 0, turn_grant=0000.
//   2 Mask 1011, start -> cur=0, turn_change, secs_left=30.
//     Then done[0] -> cur=1 -> cur=3 -> cur=0 (wrap).
//   3 30 sec_ticks on player 0 -> secs_left 30..0 and one turn_timeout pulse.
//     LOAD follows 2 cycles after the last tick with cur=1.
//   4 pause together with sec_tick at secs_left=10 -> stays 10 and tick_en=0.
//     Release pause, then 1 tick -> secs_left=9.
//   5 done[cur] and sec_tick in the same cycle at secs_left=1 -> NEXT.
//     No turn_timeout is generated.
//   6 Mask goes to 0000 during RUN, then done -> NEXT -> IDLE, busy=0.
//     abort mid-turn -> IDLE next cycle.

Source files
------------

// File: rtl/turn_timer_scheduler.sv
// Round-robin turn scheduler: grants each active player a timed turn driven by a shared 1 s tick,
// gates the seconds prescaler and reports the current player and remaining seconds.
module turn_timer_scheduler #(
   parameter int unsigned N_PLAYERS = 4,
   parameter int unsigned PW        = 2,
   parameter int unsigned TURN_SEC  = 30,
   parameter int unsigned SW        = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic                 pause_i,
   input  logic [N_PLAYERS-1:0] player_active_i,
   input  logic [N_PLAYERS-1:0] player_done_i,
   input  logic                 sec_tick_i,
   output logic                 tick_en_o,
   output logic                 clear_time_o,
   output logic [PW-1:0]        cur_player_o,
   output logic [N_PLAYERS-1:0] turn_grant_o,
   output logic [SW-1:0]        secs_left_o,
   output logic                 turn_change_o,
   output logic                 turn_timeout_o,
   output logic                 busy_o
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StLoad  = 3'd1;
   localparam logic [2:0] StRun   = 3'd2;
   localparam logic [2:0] StPause = 3'd3;
   localparam logic [2:0] StNext  = 3'd4;

   localparam logic [SW-1:0] TurnLoad = SW'(TURN_SEC);

   logic [2:0]    state_q, state_d;
   logic [PW-1:0] cur_q, cur_d;
   logic [SW-1:0] secs_q, secs_d;
   logic          timeout_q, timeout_d;

   logic          first_found, next_found;
   logic [PW-1:0] first_idx, next_idx, cand;

   // Lowest active slot for game start; first active slot after cur_q (wrapping) for hand-over.
   always_comb begin
      first_found = 1'b0;
      first_idx   = '0;
      next_found  = 1'b0;
      next_idx    = '0;
      cand        = '0;
      for (int unsigned i = 0; i < N_PLAYERS; i++) begin
         if (!first_found && player_active_i[PW'(i)]) begin
            first_found = 1'b1;
            first_idx   = PW'(i);
         end
      end
      for (int unsigned k = 1; k <= N_PLAYERS; k++) begin
         cand = PW'((32'(cur_q) + k) % N_PLAYERS);
         if (!next_found && player_active_i[cand]) begin
            next_found = 1'b1;
            next_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      secs_d    = secs_q;
      timeout_d = 1'b0;
      if (abort_i) begin
         state_d = StIdle;
         secs_d  = '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start_i && first_found) begin
                  state_d = StLoad;
                  cur_d   = first_idx;
               end
            end
            StLoad: begin
               secs_d  = TurnLoad;
               state_d = StRun;
            end
            StRun: begin
               // Pause wins over done, done wins over the tick.
               if (pause_i) begin
                  state_d = StPause;
               end else if (player_done_i[cur_q]) begin
                  state_d = StNext;
               end else if (sec_tick_i) begin
                  if (secs_q <= SW'(1)) begin
                     secs_d    = '0;
                     timeout_d = 1'b1;
                     state_d   = StNext;
                  end else begin
                     secs_d = secs_q - SW'(1);
                  end
               end
            end
            StPause: begin
               if (!pause_i) begin
                  state_d = StRun;
               end
            end
            StNext: begin
               if (next_found) begin
                  state_d = StLoad;
                  cur_d   = next_idx;
               end else begin
                  state_d = StIdle;
                  secs_d  = '0;
               end
            end
            default: begin
               state_d = StIdle;
               secs_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         cur_q     <= '0;
         secs_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         secs_q    <= secs_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      turn_grant_o = '0;
      if (state_q == StLoad || state_q == StRun || state_q == StPause) begin
         turn_grant_o[cur_q] = 1'b1;
      end
   end

   assign tick_en_o      = (state_q == StRun);
   assign clear_time_o   = (state_q == StLoad);
   assign turn_change_o  = (state_q == StLoad);
   assign busy_o         = (state_q != StIdle);
   assign cur_player_o   = cur_q;
   assign secs_left_o    = secs_q;
   assign turn_timeout_o = timeout_q;

endmodule

// File: tb/tb_turn_timer_scheduler.sv
// Directed bench for turn_timer_scheduler: reset, rotation, timeout, pause, done-vs-tick,
// empty mask, re-grant, abort and mid-turn reset.
module tb_turn_timer_scheduler;

   logic       clk;
   logic       rst;
   logic       start, abort, pause, sec_tick;
   logic [3:0] player_active, player_done;
   logic       tick_en, clear_time, turn_change, turn_timeout, busy;
   logic [1:0] cur_player;
   logic [3:0] turn_grant;
   logic [5:0] secs_left;

   int errors = 0;
   int checks = 0;

   turn_timer_scheduler #(
      .N_PLAYERS(4),
      .PW       (2),
      .TURN_SEC (30),
      .SW       (6)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start_i        (start),
      .abort_i        (abort),
      .pause_i        (pause),
      .player_active_i(player_active),
      .player_done_i  (player_done),
      .sec_tick_i     (sec_tick),
      .tick_en_o      (tick_en),
      .clear_time_o   (clear_time),
      .cur_player_o   (cur_player),
      .turn_grant_o   (turn_grant),
      .secs_left_o    (secs_left),
      .turn_change_o  (turn_change),
      .turn_timeout_o (turn_timeout),
      .busy_o         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_reset(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_tick_en"}, 32'(tick_en), 0);
      chk({tag, "_clear"}, 32'(clear_time), 0);
      chk({tag, "_cur"}, 32'(cur_player), 0);
      chk({tag, "_grant"}, 32'(turn_grant), 0);
      chk({tag, "_secs"}, 32'(secs_left), 0);
      chk({tag, "_change"}, 32'(turn_change), 0);
      chk({tag, "_timeout"}, 32'(turn_timeout), 0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0; sec_tick = 1'b0;
      player_active = 4'b0000; player_done = 4'b0000;
      repeat (3) cyc();
      chk_idle_reset("rst0");

      // Game start with mask 1011
      rst = 1'b1; player_active = 4'b1011;
      cyc();
      chk("idle_busy", 32'(busy), 0);
      start = 1'b1; cyc(); start = 1'b0;
      chk("load_change", 32'(turn_change), 1);
      chk("load_clear", 32'(clear_time), 1);
      chk("load_cur", 32'(cur_player), 0);
      chk("load_grant", 32'(turn_grant), 1);
      chk("load_tick_en", 32'(tick_en), 0);
      chk("load_busy", 32'(busy), 1);
      cyc();
      chk("run_tick_en", 32'(tick_en), 1);
      chk("run_secs", 32'(secs_left), 30);
      chk("run_change", 32'(turn_change), 0);
      chk("run_grant", 32'(turn_grant), 1);

      // Foreign done and stray start are ignored
      player_done = 4'b0010; cyc(); player_done = 4'b0000;
      chk("foreign_done_run", 32'(tick_en), 1);
      chk("foreign_done_cur", 32'(cur_player), 0);
      start = 1'b1; cyc(); start = 1'b0;
      chk("start_in_run", 32'(tick_en), 1);
      chk("start_in_run_chg", 32'(turn_change), 0);

      // Rotation 0 -> 1 -> 3 -> 0
      player_done = 4'b0001; cyc(); player_done = 4'b0000;
      chk("next_tick_en", 32'(tick_en), 0);
      chk("next_busy", 32'(busy), 1);
      chk("next_grant", 32'(turn_grant), 0);
      cyc();
      chk("rot1_change", 32'(turn_change), 1);
      chk("rot1_cur", 32'(cur_player), 1);
      chk("rot1_grant", 32'(turn_grant), 2);
      cyc();
      chk("rot1_run", 32'(tick_en), 1);
      player_done = 4'b0010; cyc(); player_done = 4'b0000;
      cyc();
      chk("rot3_cur", 32'(cur_player), 3);
      chk("rot3_change", 32'(turn_change), 1);
      cyc();
      player_done = 4'b1000; cyc(); player_done = 4'b0000;
      cyc();
      chk("wrap_cur", 32'(cur_player), 0);
      chk("wrap_change", 32'(turn_change), 1);
      chk("wrap_grant", 32'(turn_grant), 1);
      cyc();
      chk("wrap_secs", 32'(secs_left), 30);
      chk("wrap_run", 32'(tick_en), 1);

      // Full countdown on player 0
      sec_tick = 1'b1;
      for (int k = 1; k <= 29; k++) begin
         cyc();
         chk("count_secs", 32'(secs_left), 32'(30 - k));
      end
      chk("count_no_timeout", 32'(turn_timeout), 0);
      chk("count_still_run", 32'(tick_en), 1);
      cyc(); sec_tick = 1'b0;
      chk("expire_secs", 32'(secs_left), 0);
      chk("expire_timeout", 32'(turn_timeout), 1);
      chk("expire_next", 32'(tick_en), 0);
      cyc();
      chk("expire_load", 32'(turn_change), 1);
      chk("expire_cur", 32'(cur_player), 1);
      chk("expire_pulse_end", 32'(turn_timeout), 0);
      cyc();
      chk("p1_secs", 32'(secs_left), 30);

      // Pause together with a tick at 10 seconds
      sec_tick = 1'b1;
      repeat (20) cyc();
      chk("pre_pause_secs", 32'(secs_left), 10);
      pause = 1'b1; cyc();
      chk("pause_secs", 32'(secs_left), 10);
      chk("pause_tick_en", 32'(tick_en), 0);
      chk("pause_grant", 32'(turn_grant), 2);
      cyc();
      chk("pause_hold", 32'(secs_left), 10);
      pause = 1'b0; sec_tick = 1'b0; cyc();
      chk("resume_run", 32'(tick_en), 1);
      chk("resume_secs", 32'(secs_left), 10);
      sec_tick = 1'b1; cyc(); sec_tick = 1'b0;
      chk("resume_tick", 32'(secs_left), 9);

      // Done and final tick in the same cycle
      sec_tick = 1'b1;
      repeat (8) cyc();
      chk("at_one_secs", 32'(secs_left), 1);
      player_done = 4'b0010; cyc(); player_done = 4'b0000; sec_tick = 1'b0;
      chk("donetick_next", 32'(tick_en), 0);
      chk("donetick_secs", 32'(secs_left), 1);
      chk("donetick_no_to", 32'(turn_timeout), 0);
      cyc();
      chk("donetick_cur", 32'(cur_player), 3);
      chk("donetick_change", 32'(turn_change), 1);
      chk("donetick_no_to2", 32'(turn_timeout), 0);
      cyc();

      // Mask empties mid-turn
      player_active = 4'b0000; cyc();
      chk("empty_run", 32'(tick_en), 1);
      chk("empty_grant", 32'(turn_grant), 8);
      player_done = 4'b1000; cyc(); player_done = 4'b0000;
      chk("empty_next_busy", 32'(busy), 1);
      cyc();
      chk("empty_idle_busy", 32'(busy), 0);
      chk("empty_idle_secs", 32'(secs_left), 0);
      chk("empty_idle_grant", 32'(turn_grant), 0);
      start = 1'b1; cyc(); start = 1'b0;
      chk("empty_start", 32'(busy), 0);

      // Sole active player is re-granted
      player_active = 4'b0100;
      start = 1'b1; cyc(); start = 1'b0;
      chk("solo_cur", 32'(cur_player), 2);
      chk("solo_change", 32'(turn_change), 1);
      cyc();
      player_done = 4'b0100; cyc(); player_done = 4'b0000;
      cyc();
      chk("regrant_cur", 32'(cur_player), 2);
      chk("regrant_change", 32'(turn_change), 1);
      cyc();
      chk("regrant_run", 32'(tick_en), 1);

      // Abort mid-turn
      sec_tick = 1'b1; cyc(); cyc(); sec_tick = 1'b0;
      chk("pre_abort_secs", 32'(secs_left), 28);
      abort = 1'b1; cyc();
      chk("abort_busy", 32'(busy), 0);
      chk("abort_secs", 32'(secs_left), 0);
      chk("abort_cur", 32'(cur_player), 2);
      chk("abort_grant", 32'(turn_grant), 0);
      chk("abort_tick_en", 32'(tick_en), 0);
      abort = 1'b0;

      // Reset mid-RUN
      start = 1'b1; cyc(); start = 1'b0;
      cyc();
      sec_tick = 1'b1; cyc(); sec_tick = 1'b0;
      chk("pre_rst_secs", 32'(secs_left), 29);
      rst = 1'b0;
      repeat (3) cyc();
      chk_idle_reset("rst_mid");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
